uart_rx_fifo: RTL

Parametrised oversampling UART receiver with a built-in receive FIFO. It replaces the fixed 8x / 8-bit receiver on each MIDI input port of the router. It adds:
- configurable oversample ratio and data width,
- framing-error detection,
- a valid/ready byte FIFO so the routing logic can absorb bursts,
- optional parity checking.

---
 rtl/uart_rx_fifo.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_fifo.sv
`timescale 1ns/1ps
// uart_rx_fifo: oversampling UART receiver with majority-vote sampling feeding a valid/ready byte FIFO.
// Define UART_RX_PARITY_EN to add an even-parity bit, the PARITY state and the parity_err pulse.
module uart_rx_fifo #(
    parameter int OVERSAMPLE = 8,
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          uart_in,
    output logic [DATA_BITS-1:0]          rd_data,
    output logic                          rd_valid,
    input  logic                          rd_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          frame_err,
    output logic                          overrun,
    output logic                          parity_err
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int M  = OVERSAMPLE / 2;

    localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
    localparam logic [CW-1:0] CNT_S0   = CW'(M - 1);
    localparam logic [CW-1:0] CNT_S1   = CW'(M);
    localparam logic [CW-1:0] CNT_S2   = CW'(M + 1);
    localparam logic [CW-1:0] CNT_STOP = CW'(M + 2);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);
    localparam logic [PW:0]   FULL_CNT = (PW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [BW-1:0]          bitcnt_q, bitcnt_d;
    logic [2:0]             samp_q, samp_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   frame_err_q, frame_err_d;
    logic                   overrun_q, overrun_d;
    logic                   sync1_q, sync2_q, prev_q;
    logic                   fall, vote, good, push, pop, full;

    logic [DATA_BITS-1:0]   mem_q [FIFO_DEPTH];
    logic [PW-1:0]          wptr_q, rptr_q;
    logic [PW:0]            count_q;

`ifdef UART_RX_PARITY_EN
    logic                   parity_bad_q, parity_bad_d;
    logic                   parity_err_q, parity_err_d;
`endif

    // Synchroniser idles high so reset never looks like a start edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= uart_in;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign fall = prev_q & ~sync2_q;
    assign vote = (samp_q[0] & samp_q[1]) | (samp_q[0] & samp_q[2]) | (samp_q[1] & samp_q[2]);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bitcnt_q    <= '0;
            samp_q      <= '0;
            shift_q     <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_bad_q <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bitcnt_q    <= bitcnt_d;
            samp_q      <= samp_d;
            shift_q     <= shift_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
`ifdef UART_RX_PARITY_EN
            parity_bad_q <= parity_bad_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + 1'b1;
        bitcnt_d    = bitcnt_q;
        samp_d      = samp_q;
        shift_d     = shift_q;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;
        good        = 1'b0;
        push        = 1'b0;
`ifdef UART_RX_PARITY_EN
        parity_bad_d = parity_bad_q;
        parity_err_d = 1'b0;
`endif

        if (state_q != IDLE) begin
            if (cnt_q == CNT_S0) samp_d[0] = sync2_q;
            if (cnt_q == CNT_S1) samp_d[1] = sync2_q;
            if (cnt_q == CNT_S2) samp_d[2] = sync2_q;
        end

        unique case (state_q)
            IDLE: begin
                cnt_d    = '0;
                bitcnt_d = '0;
                if (fall) state_d = START;
            end
            START: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = vote ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d    = '0;
                    shift_d  = {vote, shift_q[DATA_BITS-1:1]};
                    bitcnt_d = bitcnt_q + 1'b1;
                    if (bitcnt_q == BIT_LAST) begin
                        bitcnt_d = '0;
`ifdef UART_RX_PARITY_EN
                        state_d  = PARITY;
`else
                        state_d  = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d        = '0;
                    parity_bad_d = vote ^ (^shift_q);
                    state_d      = STOP;
                end
            end
`endif
            STOP: begin
                // Decide early in the stop bit to leave resync margin for a fast sender.
                if (cnt_q == CNT_STOP) begin
                    cnt_d       = '0;
                    state_d     = IDLE;
                    frame_err_d = ~vote;
`ifdef UART_RX_PARITY_EN
                    parity_err_d = parity_bad_q;
                    good         = vote & ~parity_bad_q;
`else
                    good         = vote;
`endif
                    if (good) begin
                        if (!full || pop) push = 1'b1;
                        else              overrun_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign full = (count_q == FULL_CNT);
    assign pop  = (count_q != '0) & rd_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_q   <= '{default: '0};
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                mem_q[wptr_q] <= shift_q;
                wptr_q        <= wptr_q + 1'b1;
            end
            if (pop) rptr_q <= rptr_q + 1'b1;
            if (push && !pop)      count_q <= count_q + 1'b1;
            else if (pop && !push) count_q <= count_q - 1'b1;
        end
    end

    assign rd_data    = mem_q[rptr_q];
    assign rd_valid   = (count_q != '0);
    assign fifo_count = count_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule
